// File: rtl/uart_rx_frontend_pkg.sv
// Shared types, constants and helpers for the oversampling UART receive front end.
package uart_rx_frontend_pkg;

  localparam int unsigned DSIZE     = 8;
  localparam int unsigned PSC_W     = 6;
  localparam int unsigned BIT_CNT_W = $clog2(DSIZE);

  localparam logic [PSC_W-1:0] PSC_8  = PSC_W'(8);
  localparam logic [PSC_W-1:0] PSC_16 = PSC_W'(16);
  localparam logic [PSC_W-1:0] PSC_32 = PSC_W'(32);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  typedef struct packed {
    logic [DSIZE-1:0] data;
    logic             data_valid;
    logic             parity_error;
    logic             stop_error;
  } rx_out_t;

  // Unsupported ratios fall back to 8x oversampling.
  function automatic logic [PSC_W-1:0] psc_decode(input logic [PSC_W-1:0] psc);
    case (psc)
      PSC_8, PSC_16, PSC_32: return psc;
      default:               return PSC_8;
    endcase
  endfunction

  // Bit periods in one frame: start, data, optional parity, stop.
  function automatic int unsigned frame_len(input logic par_en);
    return DSIZE + 2 + (par_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Received-byte bus: deframed data plus per-frame result strobes.
interface uart_rx_frontend_if;
  import uart_rx_frontend_pkg::*;

  logic [DSIZE-1:0] P_DATA;
  logic             data_valid;
  logic             parity_error;
  logic             stop_error;

  modport master (output P_DATA, output data_valid, output parity_error, output stop_error);
  modport slave  (input  P_DATA, input  data_valid, input  parity_error, input  stop_error);
endinterface

// File: rtl/uart_rx_frontend_sampler.sv
// Per-bit edge counter with three-point mid-bit capture and majority vote.
module uart_rx_frontend_sampler
  import uart_rx_frontend_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PSC_W-1:0] psc,
  input  logic             rx_s,
  output logic             sample_done_c,
  output logic             bit_done_c,
  output logic             bit_val_c
);

  logic [PSC_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PSC_W-1:0] half_c;
  logic             s0_q, s0_d;
  logic             s1_q, s1_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
    end
  end

  // Third sample is the live rx_s, so the vote resolves on the P/2+1 cycle itself.
  always_comb begin
    half_c        = psc >> 1;
    s0_d          = s0_q;
    s1_d          = s1_q;
    edge_cnt_d    = '0;
    bit_done_c    = en && (edge_cnt_q == psc - PSC_W'(1));
    sample_done_c = en && (edge_cnt_q == half_c + PSC_W'(1));
    bit_val_c     = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

    if (en) begin
      if (edge_cnt_q == half_c - PSC_W'(1)) s0_d = rx_s;
      if (edge_cnt_q == half_c)             s1_d = rx_s;
      edge_cnt_d = bit_done_c ? '0 : edge_cnt_q + PSC_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive deframer: synchronises RX_IN, walks start/data/parity/stop
// and reports each frame as exactly one of data_valid, parity_error, stop_error.
module uart_rx_frontend
  import uart_rx_frontend_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic [PSC_W-1:0]  Prescale,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  uart_rx_frontend_if.master rx_out
);

  logic                 rx_meta_q, rx_s_q;
  rx_state_e            state_q, state_d;
  logic [PSC_W-1:0]     psc_q, psc_d;
  logic                 par_en_q, par_en_d;
  logic                 par_typ_q, par_typ_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DSIZE-1:0]     shift_q, shift_d;
  logic                 par_flag_q, par_flag_d;
  rx_out_t              out_q, out_d;
  logic                 exp_par_c;
  logic                 sample_done_c, bit_done_c, bit_val_c;

  // Two-flop synchroniser, idles high so reset never looks like a start bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX_IN;
      rx_s_q    <= rx_meta_q;
    end
  end

  uart_rx_frontend_sampler u_sampler (
    .clk           (CLK),
    .rst_n         (RST),
    .en            (state_q != ST_IDLE),
    .psc           (psc_q),
    .rx_s          (rx_s_q),
    .sample_done_c (sample_done_c),
    .bit_done_c    (bit_done_c),
    .bit_val_c     (bit_val_c)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      psc_q      <= PSC_8;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_flag_q <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      psc_q      <= psc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_flag_q <= par_flag_d;
      out_q      <= out_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    psc_d              = psc_q;
    par_en_d           = par_en_q;
    par_typ_d          = par_typ_q;
    bit_cnt_d          = bit_cnt_q;
    shift_d            = shift_q;
    par_flag_d         = par_flag_q;
    out_d              = out_q;
    out_d.data_valid   = 1'b0;
    out_d.parity_error = 1'b0;
    out_d.stop_error   = 1'b0;
    exp_par_c          = par_typ_q ? ~(^shift_q) : ^shift_q;

    case (state_q)
      ST_IDLE: begin
        // Frame configuration is frozen here for the whole frame.
        if (!rx_s_q) begin
          state_d    = ST_START;
          psc_d      = psc_decode(Prescale);
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          bit_cnt_d  = '0;
          par_flag_d = 1'b0;
        end
      end
      ST_START: begin
        if (sample_done_c && bit_val_c) state_d = ST_IDLE;
        else if (bit_done_c)            state_d = ST_DATA;
      end
      ST_DATA: begin
        if (sample_done_c) shift_d = {bit_val_c, shift_q[DSIZE-1:1]};
        if (bit_done_c) begin
          if (bit_cnt_q == BIT_CNT_W'(DSIZE-1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (sample_done_c) par_flag_d = (bit_val_c != exp_par_c);
        if (bit_done_c)    state_d    = ST_STOP;
      end
      ST_STOP: begin
        // Leave at the resolve point so a start bit right after stop is not missed.
        if (sample_done_c) begin
          state_d = ST_IDLE;
          if (!bit_val_c)      out_d.stop_error   = 1'b1;
          else if (par_flag_q) out_d.parity_error = 1'b1;
          else begin
            out_d.data_valid = 1'b1;
            out_d.data       = shift_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_out.P_DATA       = out_q.data;
  assign rx_out.data_valid   = out_q.data_valid;
  assign rx_out.parity_error = out_q.parity_error;
  assign rx_out.stop_error   = out_q.stop_error;

endmodule
